// File: rtl/cordic_result_capture.sv
// ============================================================================
// cordic_result_capture
// Tags CORDIC core outputs via a latency-matched valid delay line, buffers
// them in a small first-word-fall-through FIFO with credit-based in_ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cordic_result_capture #(
  parameter int N       = 31,
  parameter int AW      = 16,
  parameter int LATENCY = 16,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_issue,
  output logic                     in_ready,
  input  logic [N:0]               pf,
  input  logic [N:0]               qf,
  input  logic [AW-1:0]            output_angle,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N:0]               out_pf,
  output logic [N:0]               out_qf,
  output logic [AW-1:0]            out_angle,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(LATENCY + 1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [IW-1:0]      inflight_q, inflight_d;
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;

  logic [N:0]         mem_pf_q  [DEPTH];
  logic [N:0]         mem_qf_q  [DEPTH];
  logic [AW-1:0]      mem_ang_q [DEPTH];

  logic               cap;
  logic               full;
  logic               pop;
  logic               push;

  generate
    if (LATENCY == 1) begin : g_lat1
      assign vld_d = in_issue;
    end else begin : g_latn
      assign vld_d = {vld_q[LATENCY-2:0], in_issue};
    end
  endgenerate

  always_comb begin
    cap        = vld_q[LATENCY-1];
    full       = (count_q == CW'(DEPTH));
    out_valid  = (count_q != '0);
    pop        = out_valid && out_ready;
    // A capture while full only lands if the head leaves in the same cycle.
    push       = cap && (!full || pop);

    inflight_d = inflight_q;
    case ({in_issue, cap})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
    ovf_d  = ovf_q || (cap && full && !pop);

    in_ready  = (SW'(count_q) + SW'(inflight_q)) < SW'(DEPTH);
    count     = count_q;
    overflow  = ovf_q;
    out_pf    = mem_pf_q[rptr_q];
    out_qf    = mem_qf_q[rptr_q];
    out_angle = mem_ang_q[rptr_q];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q      <= '0;
      inflight_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage is cleared on reset so the fall-through outputs read zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pf_q[i]  <= '0;
        mem_qf_q[i]  <= '0;
        mem_ang_q[i] <= '0;
      end
    end else if (push) begin
      mem_pf_q[wptr_q]  <= pf;
      mem_qf_q[wptr_q]  <= qf;
      mem_ang_q[wptr_q] <= output_angle;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cordic_result_capture.sv
// ============================================================================
// tb_cordic_result_capture
// Directed and randomized checks against a queue-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cordic_result_capture;

  localparam int N     = 31;
  localparam int AW    = 16;
  localparam int L     = 16;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_issue;
  logic            in_ready;
  logic [N:0]      pf, qf;
  logic [AW-1:0]   output_angle;
  logic            out_valid;
  logic            out_ready;
  logic [N:0]      out_pf, out_qf;
  logic [AW-1:0]   out_angle;
  logic [$clog2(DEPTH):0] count;
  logic            overflow;

  cordic_result_capture #(.N(N), .AW(AW), .LATENCY(L), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_issue(in_issue), .in_ready(in_ready),
    .pf(pf), .qf(qf), .output_angle(output_angle),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pf(out_pf), .out_qf(out_qf), .out_angle(out_angle),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N:0]    pf;
    logic [N:0]    qf;
    logic [AW-1:0] a;
  } ent_t;

  ent_t fq[$];
  int   pend[$];
  bit   m_ovf;
  int   k;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    fq.delete();
    pend.delete();
    m_ovf = 1'b0;
  endtask

  task automatic check_state();
    check_eq("valid",    64'(out_valid), 64'(fq.size() != 0));
    check_eq("count",    64'(count),     64'(fq.size()));
    check_eq("in_ready", 64'(in_ready),  64'((fq.size() + pend.size()) < DEPTH));
    check_eq("overflow", 64'(overflow),  64'(m_ovf));
    if (fq.size() != 0) begin
      check_eq("head_pf",  64'(out_pf),    64'(fq[0].pf));
      check_eq("head_qf",  64'(out_qf),    64'(fq[0].qf));
      check_eq("head_ang", 64'(out_angle), 64'(fq[0].a));
    end
  endtask

  // One clock edge: advance the model with the inputs the DUT just sampled.
  task automatic tick();
    bit cap, pop;
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else begin
      k++;
      pop = (fq.size() != 0) && out_ready;
      cap = (pend.size() != 0) && (pend[0] == k);
      if (cap) void'(pend.pop_front());
      if (pop) void'(fq.pop_front());
      if (cap) begin
        if (fq.size() < DEPTH) fq.push_back('{pf: pf, qf: qf, a: output_angle});
        else m_ovf = 1'b1;
      end
      if (in_issue) pend.push_back(k + L);
    end
    #1;
    check_state();
  endtask

  task automatic drive_rand();
    pf           = $urandom;
    qf           = $urandom;
    output_angle = AW'($urandom);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    #1;
    model_clear();
    check_eq("rst_valid",    64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready),  64'd1);
    check_eq("rst_count",    64'(count),     64'd0);
    check_eq("rst_overflow", 64'(overflow),  64'd0);
    check_eq("rst_pf",       64'(out_pf),    64'd0);
    check_eq("rst_qf",       64'(out_qf),    64'd0);
    check_eq("rst_ang",      64'(out_angle), 64'd0);
    repeat (cycles) tick();
    rst = 1'b1;
  endtask

  initial begin
    int vcount, first, last;
    k         = 0;
    rst       = 1'b1;
    in_issue  = 1'b0;
    out_ready = 1'b0;
    pf        = 32'hDEADBEEF;
    qf        = 32'hDEADBEEF;
    output_angle = 16'hBEEF;
    model_clear();
    #2;

    // Reset and single issue
    do_reset(13);
    repeat (2) tick();
    in_issue = 1'b1;
    tick();
    in_issue = 1'b0;
    repeat (L - 1) tick();
    pf = 32'h00000500; qf = 32'h0; output_angle = 16'h0E56;
    tick();
    pf = 32'hDEADBEEF; qf = 32'hDEADBEEF; output_angle = 16'hBEEF;
    check_eq("t1_valid", 64'(out_valid), 64'd1);
    check_eq("t1_pf",    64'(out_pf),    64'h500);
    check_eq("t1_qf",    64'(out_qf),    64'h0);
    check_eq("t1_ang",   64'(out_angle), 64'h0E56);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("t1_count_after_pop", 64'(count), 64'd0);

    // Credit back-pressure
    for (int i = 0; i < 4; i++) begin
      in_issue = 1'b1; drive_rand(); tick();
    end
    in_issue = 1'b0;
    check_eq("t2_in_ready_low", 64'(in_ready), 64'd0);
    repeat (L) begin drive_rand(); tick(); end
    check_eq("t2_count", 64'(count), 64'd4);
    check_eq("t2_ovf",   64'(overflow), 64'd0);

    // Overflow from full
    in_issue = 1'b1; drive_rand(); tick(); in_issue = 1'b0;
    check_eq("t3_in_ready_low", 64'(in_ready), 64'd0);
    repeat (L + 1) begin drive_rand(); tick(); end
    check_eq("t3_ovf",   64'(overflow), 64'd1);
    check_eq("t3_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    repeat (6) begin drive_rand(); tick(); end
    out_ready = 1'b0;
    check_eq("t3_drained", 64'(count), 64'd0);
    check_eq("t3_ovf_sticky", 64'(overflow), 64'd1);

    // Full with simultaneous push and pop
    do_reset(2);
    for (int i = 0; i < 4; i++) begin in_issue = 1'b1; drive_rand(); tick(); end
    in_issue = 1'b0;
    repeat (L) begin drive_rand(); tick(); end
    check_eq("t4_full", 64'(count), 64'd4);
    for (int i = 0; i < 3; i++) begin in_issue = 1'b1; drive_rand(); tick(); end
    in_issue = 1'b0;
    repeat (L - 3) begin drive_rand(); tick(); end
    out_ready = 1'b1;
    repeat (3) begin drive_rand(); tick(); end
    check_eq("t4_count_held", 64'(count), 64'd4);
    check_eq("t4_ovf",        64'(overflow), 64'd0);
    repeat (5) begin drive_rand(); tick(); end
    out_ready = 1'b0;
    check_eq("t4_drained", 64'(count), 64'd0);

    // Streaming
    out_ready = 1'b1;
    vcount = 0; first = -1; last = -1;
    for (int j = 0; j < 20 + L + 4; j++) begin
      in_issue = (j < 20);
      pf = 32'h1000 + 32'(j);
      qf = $urandom; output_angle = AW'($urandom);
      tick();
      if (out_valid) begin
        vcount++;
        if (first < 0) begin
          first = j;
          check_eq("t5_first_pf", 64'(out_pf), 64'(32'h1000 + L));
        end
        last = j;
      end
    end
    in_issue = 1'b0;
    check_eq("t5_nvalid", 64'(vcount), 64'd20);
    check_eq("t5_first",  64'(first),  64'(L));
    check_eq("t5_last",   64'(last),   64'(L + 19));
    check_eq("t5_ovf",    64'(overflow), 64'd0);

    // Reset mid-flight: load one result first so storage is non-zero
    out_ready = 1'b0;
    in_issue = 1'b1; drive_rand(); tick(); in_issue = 1'b0;
    repeat (L) begin drive_rand(); tick(); end
    for (int i = 0; i < 3; i++) begin in_issue = 1'b1; drive_rand(); tick(); end
    in_issue = 1'b0;
    repeat (2) begin drive_rand(); tick(); end
    do_reset(1);
    vcount = 0;
    repeat (L + 4) begin
      drive_rand(); tick();
      if (out_valid) vcount++;
    end
    check_eq("t6_no_valid", 64'(vcount), 64'd0);
    check_eq("t6_in_ready", 64'(in_ready), 64'd1);

    // Randomized traffic
    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset(1);
      end
      in_issue  = in_ready ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 9) < 1);
      out_ready = ($urandom_range(0, 9) < 6);
      drive_rand();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
